// File: rtl/fft_pkg.sv
// fft_pkg: shared constants for the FFT peripheral -- register offsets, FSM state
// encoding, the 16-entry Q1.15 twiddle ROM and the bit-reversal helper.
package fft_pkg;

    localparam logic [13:0] REG_CTRL = 14'd0;
    localparam logic [13:0] REG_DIN  = 14'd1;
    localparam logic [13:0] REG_RIDX = 14'd2;
    localparam logic [13:0] REG_RRE  = 14'd3;
    localparam logic [13:0] REG_RIM  = 14'd4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } fft_state_e;

    // {cos, sin} of 2*pi*k/16 in Q1.15; +1.0 saturates to 0x7FFF.
    function automatic logic [31:0] tw_rom(input logic [3:0] k);
        logic [31:0] v;
        v = 32'h7FFF_0000;
        case (k)
            4'd0:  v = 32'h7FFF_0000;
            4'd1:  v = 32'h7642_30FC;
            4'd2:  v = 32'h5A82_5A82;
            4'd3:  v = 32'h30FC_7642;
            4'd4:  v = 32'h0000_7FFF;
            4'd5:  v = 32'hCF04_7642;
            4'd6:  v = 32'hA57E_5A82;
            4'd7:  v = 32'h89BE_30FC;
            4'd8:  v = 32'h8000_0000;
            4'd9:  v = 32'h89BE_CF04;
            4'd10: v = 32'hA57E_A57E;
            4'd11: v = 32'hCF04_89BE;
            4'd12: v = 32'h0000_8000;
            4'd13: v = 32'h30FC_89BE;
            4'd14: v = 32'h5A82_A57E;
            4'd15: v = 32'h7642_CF04;
            default: v = 32'h7FFF_0000;
        endcase
        return v;
    endfunction

    // Reverse all four bits, then drop the unused low positions for shorter transforms.
    function automatic logic [3:0] bitrev(input logic [3:0] n, input logic [2:0] sh);
        logic [3:0] r;
        r = {n[0], n[1], n[2], n[3]};
        return r >> sh;
    endfunction

endpackage

// File: rtl/fft_r2_bfly.sv
// fft_r2_bfly: combinational radix-2 DIT butterfly A' = A + W*B, B' = A - W*B.
// Build option: FFT_STAGE_SCALE_EN halves both outputs (arithmetic shift right 1).
module fft_r2_bfly
    import fft_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic signed [DW-1:0] i_a_re,
    input  logic signed [DW-1:0] i_a_im,
    input  logic signed [DW-1:0] i_b_re,
    input  logic signed [DW-1:0] i_b_im,
    input  logic        [3:0]    i_tw_idx,
    output logic signed [DW-1:0] o_a_re,
    output logic signed [DW-1:0] o_a_im,
    output logic signed [DW-1:0] o_b_re,
    output logic signed [DW-1:0] o_b_im
);
    logic        [31:0]    w_rom;
    logic signed [DW+16:0] w_br, w_bi, w_c, w_s, w_pre, w_pim;
    logic signed [DW+1:0]  w_tre, w_tim, w_sar, w_sai, w_sbr, w_sbi;
    logic                  w_unused;

    assign w_rom = tw_rom(i_tw_idx);
    assign w_c   = (DW+17)'($signed(w_rom[31:16]));
    assign w_s   = (DW+17)'($signed(w_rom[15:0]));
    assign w_br  = (DW+17)'(i_b_re);
    assign w_bi  = (DW+17)'(i_b_im);

    // W = cos - j*sin, so W*B = (Br*c + Bi*s) + j(Bi*c - Br*s); round half up before >>> 15.
    assign w_pre = w_br * w_c + w_bi * w_s + (DW+17)'(16384);
    assign w_pim = w_bi * w_c - w_br * w_s + (DW+17)'(16384);

    // Twiddle 0 is exact unity, so bypass the saturated 0x7FFF multiplier path.
    assign w_tre = (i_tw_idx == 4'd0) ? (DW+2)'(i_b_re) : w_pre[DW+16:15];
    assign w_tim = (i_tw_idx == 4'd0) ? (DW+2)'(i_b_im) : w_pim[DW+16:15];

    assign w_sar = (DW+2)'(i_a_re) + w_tre;
    assign w_sai = (DW+2)'(i_a_im) + w_tim;
    assign w_sbr = (DW+2)'(i_a_re) - w_tre;
    assign w_sbi = (DW+2)'(i_a_im) - w_tim;

`ifdef FFT_STAGE_SCALE_EN
    assign o_a_re = w_sar[DW:1];
    assign o_a_im = w_sai[DW:1];
    assign o_b_re = w_sbr[DW:1];
    assign o_b_im = w_sbi[DW:1];
`else
    assign o_a_re = w_sar[DW-1:0];
    assign o_a_im = w_sai[DW-1:0];
    assign o_b_re = w_sbr[DW-1:0];
    assign o_b_im = w_sbi[DW-1:0];
`endif

    assign w_unused = ^{w_pre[14:0], w_pim[14:0], w_sar, w_sai, w_sbr, w_sbi};

endmodule

// File: rtl/fft_iter_periph.sv
// fft_iter_periph: bus-mapped in-place radix-2 DIT FFT, one butterfly per clock.
// Build option: define FFT_STAGE_SCALE_EN for per-stage halving (result = DFT/N).
module fft_iter_periph
    import fft_pkg::*;
#(
    parameter int          DW        = 16,
    parameter int          LOG2N     = 4,
    parameter logic [13:0] BASE_ADDR = 14'h0088
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        irq_fft,
    output logic        o_dbg_state
);
    localparam int N = 1 << LOG2N;

    fft_state_e           r_state;
    logic                 r_done, r_irq;
    logic [LOG2N-1:0]     r_wptr, r_ridx;
    logic [1:0]           r_stage;
    logic [2:0]           r_bfly;
    logic signed [DW-1:0] r_re [N];
    logic signed [DW-1:0] r_im [N];

    logic                 w_wr, w_rd, w_busy, w_last;
    logic                 w_hit_ctrl, w_hit_din, w_hit_ridx, w_hit_rre, w_hit_rim;
    logic signed [DW-1:0] w_din;
    logic [3:0]           w_b4, w_half, w_mask, w_i, w_j, w_tw, w_rev4;
    logic [LOG2N-1:0]     w_ia, w_ja, w_waddr;
    logic signed [DW-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic                 w_unused;

    assign w_wr       = per_en & (per_we == 2'b11);
    assign w_rd       = per_en & (per_we == 2'b00);
    assign w_hit_ctrl = (per_addr == BASE_ADDR + REG_CTRL);
    assign w_hit_din  = (per_addr == BASE_ADDR + REG_DIN);
    assign w_hit_ridx = (per_addr == BASE_ADDR + REG_RIDX);
    assign w_hit_rre  = (per_addr == BASE_ADDR + REG_RRE);
    assign w_hit_rim  = (per_addr == BASE_ADDR + REG_RIM);
    assign w_busy     = (r_state == ST_CALC);
    assign w_din      = DW'($signed(per_din));

    // Butterfly addressing: i = (b>>s)*2*half + (b & (half-1)); ROM index scaled to 16 entries.
    assign w_b4   = {1'b0, r_bfly};
    assign w_half = 4'd1 << r_stage;
    assign w_mask = w_half - 4'd1;
    assign w_i    = ((w_b4 & ~w_mask) << 1) | (w_b4 & w_mask);
    assign w_j    = w_i + w_half;
    assign w_tw   = (w_b4 & w_mask) << (2'd3 - r_stage);
    assign w_ia   = w_i[LOG2N-1:0];
    assign w_ja   = w_j[LOG2N-1:0];
    assign w_last = (r_stage == 2'(LOG2N-1)) && (r_bfly == 3'(N/2-1));

    assign w_rev4  = bitrev(4'(r_wptr), 3'(4-LOG2N));
    assign w_waddr = w_rev4[LOG2N-1:0];

    fft_r2_bfly #(.DW(DW)) u_bfly (
        .i_a_re   (r_re[w_ia]),
        .i_a_im   (r_im[w_ia]),
        .i_b_re   (r_re[w_ja]),
        .i_b_im   (r_im[w_ja]),
        .i_tw_idx (w_tw),
        .o_a_re   (w_a_re),
        .o_a_im   (w_a_im),
        .o_b_re   (w_b_re),
        .o_b_im   (w_b_im)
    );

    always_ff @(posedge mclk) begin
        r_irq <= 1'b0;
        if (puc_rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_wptr  <= '0;
            r_ridx  <= '0;
            r_stage <= '0;
            r_bfly  <= '0;
            for (int n = 0; n < N; n++) begin
                r_re[n] <= '0;
                r_im[n] <= '0;
            end
        end else if (r_state == ST_IDLE) begin
            if (w_wr && w_hit_ctrl) begin
                if (per_din[1]) begin
                    r_wptr <= '0;
                    r_done <= 1'b0;
                end else if (per_din[0]) begin
                    r_state <= ST_CALC;
                    r_done  <= 1'b0;
                    r_stage <= '0;
                    r_bfly  <= '0;
                end
            end
            if (w_wr && w_hit_din) begin
                r_re[w_waddr] <= w_din;
                r_im[w_waddr] <= '0;
                r_wptr        <= r_wptr + LOG2N'(1);
                r_done        <= 1'b0;
            end
            if (w_wr && w_hit_ridx) r_ridx <= per_din[LOG2N-1:0];
            if (w_rd && w_hit_rim)  r_ridx <= r_ridx + LOG2N'(1);
        end else begin
            r_re[w_ia] <= w_a_re;
            r_im[w_ia] <= w_a_im;
            r_re[w_ja] <= w_b_re;
            r_im[w_ja] <= w_b_im;
            if (w_last) begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
                r_irq   <= 1'b1;
            end else if (r_bfly == 3'(N/2-1)) begin
                r_bfly  <= '0;
                r_stage <= r_stage + 2'd1;
            end else begin
                r_bfly <= r_bfly + 3'd1;
            end
        end
    end

    // Read data is combinational in the read cycle; results are hidden while computing.
    always_comb begin
        per_dout = 16'h0000;
        if (w_rd && !puc_rst) begin
            if (w_hit_ctrl)                  per_dout = {9'd0, 5'(r_wptr), r_done, w_busy};
            else if (w_hit_ridx)             per_dout = 16'(r_ridx);
            else if (w_hit_rre && !w_busy)   per_dout = 16'($signed(r_re[r_ridx]));
            else if (w_hit_rim && !w_busy)   per_dout = 16'($signed(r_im[r_ridx]));
        end
    end

    assign irq_fft     = r_irq;
    assign o_dbg_state = r_state;
    assign w_unused    = ^{w_i, w_j, w_rev4};

endmodule

// File: tb/tb_fft_iter_periph.sv
// tb_fft_iter_periph: vector table of transforms checked against a floating-point DFT,
// plus hand-written sequences for busy-time writes, mid-run reset and read-index wrap.
`timescale 1ns/1ps
module tb_fft_iter_periph;
    localparam int          N        = 16;
    localparam logic [13:0] BASE     = 14'h0088;
    localparam int          OFF_CTRL = 0;
    localparam int          OFF_DIN  = 1;
    localparam int          OFF_RIDX = 2;
    localparam int          OFF_RRE  = 3;
    localparam int          OFF_RIM  = 4;
    localparam real         PI       = 3.14159265358979;
`ifdef FFT_STAGE_SCALE_EN
    localparam int SC   = 16;
    localparam int RTOL = 4;
`else
    localparam int SC   = 1;
    localparam int RTOL = 6;
`endif

    logic        mclk = 1'b0;
    logic        puc_rst, per_en, irq_fft, dbg_state;
    logic [13:0] per_addr;
    logic [15:0] per_din, per_dout;
    logic [1:0]  per_we;

    fft_iter_periph #(.DW(16), .LOG2N(4), .BASE_ADDR(14'h0088)) dut (
        .mclk        (mclk),
        .puc_rst     (puc_rst),
        .per_addr    (per_addr),
        .per_din     (per_din),
        .per_en      (per_en),
        .per_we      (per_we),
        .per_dout    (per_dout),
        .irq_fft     (irq_fft),
        .o_dbg_state (dbg_state)
    );

    // Clock / cycle counter
    always #5 mclk = ~mclk;
    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    typedef struct packed {
        logic [N-1:0][15:0] x;
        logic [N-1:0][15:0] er;
        logic [N-1:0][15:0] ei;
        logic [7:0]         tol;
    } vec_t;

    vec_t        vecs[6];
    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          t_start  = 0;

    task automatic check(input string name, input int got, input int exp, input int tol);
        n_checks++;
        if ((got - exp > tol) || (exp - got > tol)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, got, exp, tol);
        end
    endtask

    // Driver tasks: drive 1ns after a rising edge, reads sampled on the falling edge.
    task automatic wr(input int off, input logic [15:0] d, input logic [1:0] we);
        per_addr = BASE + 14'(off);
        per_din  = d;
        per_we   = we;
        per_en   = 1'b1;
        @(posedge mclk); #1;
        per_en  = 1'b0;
        per_we  = 2'b00;
        per_din = 16'h0000;
    endtask

    task automatic rd(input int off, output int v);
        per_addr = BASE + 14'(off);
        per_we   = 2'b00;
        per_en   = 1'b1;
        @(negedge mclk);
        v = int'($signed(per_dout));
        @(posedge mclk); #1;
        per_en = 1'b0;
    endtask

    task automatic load_and_start(input int v);
        wr(OFF_CTRL, 16'h0002, 2'b11);
        for (int n = 0; n < N; n++) wr(OFF_DIN, vecs[v].x[n], 2'b11);
        wr(OFF_CTRL, 16'h0001, 2'b11);
        t_start = cyc;
    endtask

    task automatic wait_irq(output int lat);
        lat = -1;
        for (int n = 0; n < 200 && lat < 0; n++) begin
            @(posedge mclk); #1;
            if (irq_fft) lat = cyc - t_start;
        end
    endtask

    task automatic check_bins(input int v);
        int g;
        for (int k = 0; k < N; k++) begin
            exp_q.push_back(vecs[v].er[k]);
            exp_q.push_back(vecs[v].ei[k]);
        end
        wr(OFF_RIDX, 16'h0000, 2'b11);
        for (int k = 0; k < N; k++) begin
            rd(OFF_RRE, g);
            check($sformatf("v%0d_re%0d", v, k), g, int'($signed(exp_q.pop_front())), int'(vecs[v].tol));
            rd(OFF_RIM, g);
            check($sformatf("v%0d_im%0d", v, k), g, int'($signed(exp_q.pop_front())), int'(vecs[v].tol));
        end
    endtask

    // Reference model: direct DFT in floating point, divided by N when stages are scaled.
    function automatic void model(input int v);
        for (int k = 0; k < N; k++) begin
            real sr, si, xv;
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                xv = real'(int'($signed(vecs[v].x[n])));
                sr = sr + xv * $cos(2.0 * PI * k * n / N);
                si = si - xv * $sin(2.0 * PI * k * n / N);
            end
            vecs[v].er[k] = 16'(int'(sr / SC));
            vecs[v].ei[k] = 16'(int'(si / SC));
        end
    endfunction

    initial begin
        int g, lat, seen, nz;

        // Vector table: impulse, DC, cosine (fixed expectations), three random inputs.
        for (int v = 0; v < 6; v++) vecs[v] = '0;
        vecs[0].x[0] = 16'h1000;
        for (int k = 0; k < N; k++) vecs[0].er[k] = 16'(16'h1000 / SC);
        for (int n = 0; n < N; n++) vecs[1].x[n] = 16'h0100;
        vecs[1].er[0] = 16'(16'h1000 / SC);
        for (int n = 0; n < N; n++) vecs[2].x[n] = 16'(int'(2048.0 * $cos(2.0 * PI * n / N)));
        vecs[2].er[1]  = 16'(16'h4000 / SC);
        vecs[2].er[15] = 16'(16'h4000 / SC);
        vecs[2].tol = 8'd2;
        for (int v = 3; v < 6; v++) begin
            for (int n = 0; n < N; n++) vecs[v].x[n] = 16'(int'($urandom_range(1024)) - 512);
            model(v);
            vecs[v].tol = 8'(RTOL);
        end

        // Reset
        puc_rst  = 1'b1;
        per_en   = 1'b0;
        per_we   = 2'b00;
        per_addr = 14'h0000;
        per_din  = 16'h0000;
        repeat (3) @(posedge mclk);
        #1 puc_rst = 1'b0;
        check("rst_irq", int'(irq_fft), 0, 0);
        check("rst_state", int'(dbg_state), 0, 0);
        check("rst_dout_idle", int'(per_dout), 0, 0);
        rd(OFF_CTRL, g);
        check("rst_stat", g, 0, 0);
        rd(OFF_RRE, g);
        check("rst_rre", g, 0, 0);

        // Table-driven transforms
        for (int v = 0; v < 6; v++) begin
            load_and_start(v);
            wait_irq(lat);
            check($sformatf("v%0d_latency", v), lat, 32, 0);
            @(posedge mclk); #1;
            check($sformatf("v%0d_irq_pulse", v), int'(irq_fft), 0, 0);
            rd(OFF_CTRL, g);
            check($sformatf("v%0d_stat_done", v), g, 2, 0);
            check_bins(v);
        end

        // Byte writes ignored; read index wraps after RIM at 15
        wr(OFF_DIN, 16'h1111, 2'b01);
        wr(OFF_DIN, 16'h2222, 2'b10);
        rd(OFF_CTRL, g);
        check("bytewr_stat", g, 2, 0);
        wr(OFF_RIDX, 16'h000F, 2'b11);
        rd(OFF_RIDX, g);
        check("ridx_read", g, 15, 0);
        rd(OFF_RIM, g);
        check("rim15", g, int'($signed(vecs[5].ei[15])), RTOL);
        rd(OFF_RIM, g);
        check("rim_wrap0", g, int'($signed(vecs[5].ei[0])), RTOL);
        rd(OFF_RRE, g);
        check("rre_after_wrap", g, int'($signed(vecs[5].er[1])), RTOL);

        // CLR wins over START in the same write
        wr(OFF_CTRL, 16'h0003, 2'b11);
        check("clr_prio_state", int'(dbg_state), 0, 0);
        rd(OFF_CTRL, g);
        check("clr_prio_stat", g, 0, 0);
        seen = 0;
        repeat (40) begin
            @(posedge mclk); #1;
            if (irq_fft) seen++;
        end
        check("clr_prio_no_irq", seen, 0, 0);

        // Write pointer, unmapped addresses, idle bus
        for (int n = 0; n < 3; n++) wr(OFF_DIN, 16'h0001, 2'b11);
        rd(OFF_CTRL, g);
        check("wptr3_stat", g, 12, 0);
        rd(5, g);
        check("unmapped_plus5", g, 0, 0);
        rd(-1, g);
        check("unmapped_minus1", g, 0, 0);
        check("dout_idle", int'(per_dout), 0, 0);

        // START and DIN during CALC ignored; results hidden while busy
        load_and_start(0);
        while (cyc - t_start < 10) begin
            @(posedge mclk); #1;
        end
        rd(OFF_CTRL, g);
        check("busy_stat", g, 1, 0);
        wr(OFF_CTRL, 16'h0001, 2'b11);
        wr(OFF_DIN, 16'h7777, 2'b11);
        rd(OFF_RRE, g);
        check("busy_rre_zero", g, 0, 0);
        wait_irq(lat);
        check("busy_latency", lat, 32, 0);
        rd(OFF_CTRL, g);
        check("busy_ptr_unchanged", g, 2, 0);
        check_bins(0);

        // Reset during CALC (with a simultaneous DIN write) aborts cleanly
        load_and_start(1);
        while (cyc - t_start < 5) begin
            @(posedge mclk); #1;
        end
        puc_rst  = 1'b1;
        per_addr = BASE + 14'(OFF_DIN);
        per_din  = 16'h1234;
        per_we   = 2'b11;
        per_en   = 1'b1;
        @(posedge mclk); #1;
        puc_rst = 1'b0;
        per_en  = 1'b0;
        per_we  = 2'b00;
        check("midrst_state", int'(dbg_state), 0, 0);
        rd(OFF_CTRL, g);
        check("midrst_stat", g, 0, 0);
        seen = 0;
        repeat (40) begin
            @(posedge mclk); #1;
            if (irq_fft) seen++;
        end
        check("midrst_no_irq", seen, 0, 0);
        nz = 0;
        wr(OFF_RIDX, 16'h0000, 2'b11);
        for (int k = 0; k < N; k++) begin
            rd(OFF_RRE, g);
            if (g != 0) nz++;
            rd(OFF_RIM, g);
            if (g != 0) nz++;
        end
        check("midrst_bins_nonzero", nz, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/fft_iter_periph.md
FFT_ITER_PERIPH -- requirements
Module: fft_iter_periph

Interface
REQ-001 SHALL have parameter DW, default 16, meaning sample/result width in two's complement (legal 8..24).
REQ-002 SHALL have parameter LOG2N, default 4, meaning log2 of transform length N (legal 2..4).
REQ-003 SHALL have parameter BASE_ADDR, default 14'h0088, meaning word address of register 0.
REQ-004 SHALL have port mclk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port puc_rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port per_addr, input, 14, peripheral word address.
REQ-007 SHALL have port per_din, input, 16, write data; samples sign-extended or truncated to DW.
REQ-008 SHALL have port per_en, input, 1, bus cycle enable.
REQ-009 SHALL have port per_we, input, 2, byte write enables.
REQ-010 SHALL have port per_dout, output, 16, read data; results sign-extended or truncated to 16.
REQ-011 SHALL have port irq_fft, output, 1, one-cycle completion pulse.

Function
REQ-012 Register map, word offsets from BASE_ADDR: +0 CTRL/STAT, +1 DIN, +2 RIDX, +3 RRE, +4 RIM.
REQ-013 Write occurs only when per_en=1 and per_we=2'b11; byte writes (01/10) are ignored.
REQ-014 Read occurs when per_en=1 and per_we=2'b00; per_dout is 0 in all other cycles and for unmapped addresses.
REQ-015 CTRL write: bit0=START, bit1=CLR (write pointer to 0, DONE to 0); CLR takes priority over START in the same write.
REQ-016 STAT read: bit0=BUSY, bit1=DONE, bits[6:2]=write pointer; other bits 0.
REQ-017 DIN write stores sample n = write pointer at buffer address bitrev(n), imag 0; pointer increments modulo N; DONE clears.
REQ-018 RIDX write sets read index k (low LOG2N bits); RRE returns Re X[k]; an RIM read returns Im X[k], then k increments modulo N.
REQ-019 While BUSY: DIN, CLR, RIDX writes and further START writes are ignored; RRE/RIM read 0.
REQ-020 FSM states IDLE, CALC: START in IDLE enters CALC on the next edge (BUSY=1); DONE clears.
REQ-021 CALC performs one radix-2 DIT butterfly per cycle, stage s=0..LOG2N-1, butterfly b=0..N/2-1: half=2^s, i=(b>>s)*2*half+(b&(half-1)), j=i+half, twiddle index (b&(half-1))*N/(2*half).
REQ-022 Butterfly: A'=A+W*B, B'=A-W*B, written back in place at i,j in the same cycle.
REQ-023 Twiddle W=cos-j*sin, Q1.15; product rounded (add 2^14, arithmetic shift right 15); index 0 bypasses the multiplier (exact unity).
REQ-024 Sums wrap modulo 2^DW unless REQ-029 applies.
REQ-025 Latency: with START accepted at edge t, BUSY=0, DONE=1 and irq_fft=1 for one cycle at edge t+(N/2)*LOG2N (32 cycles for N=16); results are in natural order.

Reset
REQ-026 On puc_rst, SHALL clear the buffer, write pointer, read index, BUSY, DONE, irq_fft and per_dout to 0, and return the FSM to IDLE, aborting any CALC.
REQ-027 puc_rst SHALL override any bus write in the same cycle.

Configuration
REQ-028 Macro FFT_STAGE_SCALE_EN SHALL select per-stage scaling.
REQ-029 With FFT_STAGE_SCALE_EN defined, both butterfly outputs SHALL be arithmetic-shifted right 1 per stage (result = DFT/N, no overflow); without it, REQ-024 wrap applies unscaled.

Structure
REQ-030 Package fft_pkg SHALL hold the 16-entry Q1.15 cos/sin twiddle ROM (indexed k*16/N), register offset constants and the FSM state enum.
REQ-031 SHALL instantiate one sub-module fft_r2_bfly (combinational butterfly incl. twiddle multiply, rounding, optional scaling).

Verification
REQ-032 Impulse: x[0]=0x1000, rest 0, START -> all X[k].re=0x1000, im=0 (scaled: 0x0100); irq_fft exactly 32 cycles after START.
REQ-033 DC: 16 x 0x0100 -> X[0].re=0x1000, all other bins 0 (scaled: 0x0100, others 0).
REQ-034 Cosine x[n]=round(0x0800*cos(2*pi*n/16)) -> X[1].re=X[15].re=0x4000 +/-2 LSB, others |.|<=2 (scaled: 0x0400).
REQ-035 START and DIN written at cycle 10 of CALC -> ignored; latency unchanged; pointer unchanged; RRE reads 0 while BUSY.
REQ-036 puc_rst at cycle 5 of CALC -> next cycle BUSY=0, DONE=0, STAT=0, no irq_fft pulse, all bins read 0.
REQ-037 Byte write (per_we=01) to DIN -> pointer unchanged; RIDX=15 followed by two RIM reads -> second RIM read returns Im X[0].
